// File: rtl/mips_isa_pkg.sv
// MIPS subset encodings and shared types for the decode-stage hazard logic.
package mips_isa_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned FUNC_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [FUNC_W-1:0] FUNC_JR = 6'b001000;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_W-1:0] REG_RA   = 5'd31;

    // Destination of one pipeline stage.
    typedef struct packed {
        logic             we;
        logic [REG_W-1:0] ws;
    } dest_t;

    // Register-read usage of the decode-stage instruction.
    typedef struct packed {
        logic re1;
        logic re2;
    } reads_t;

endpackage

// File: rtl/dest_decoder.sv
// Decodes the destination register of one pipeline stage and its forwarding class.
module dest_decoder
    import mips_isa_pkg::*;
(
    input  logic [XLEN-1:0]  inst,
    output logic [REG_W-1:0] ws,
    output logic             we,
    output logic             we_bypass,
    output logic             we_stall
);

    logic [OP_W-1:0]   op;
    logic [FUNC_W-1:0] func;
    dest_t             dest;
    logic              late_result;
    logic              unused_fields;

    assign op            = inst[31:26];
    assign func          = inst[5:0];
    assign unused_fields = ^{inst[25:21], inst[10:6]};

    // Destination select; a $0 target is folded into "no write".
    always_comb begin
        dest.ws = REG_ZERO;
        unique case (op)
            OP_RTYPE: dest.ws = (func != FUNC_JR) ? inst[15:11] : REG_ZERO;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: dest.ws = inst[20:16];
            OP_JAL:   dest.ws = REG_RA;
            default:  dest.ws = REG_ZERO;
        endcase
        dest.we = (dest.ws != REG_ZERO);
    end

    // Load data and the jal link value are not available from the EXE ALU.
    assign late_result = (op == OP_LW) || (op == OP_JAL);

    assign ws        = dest.ws;
    assign we        = dest.we;
    assign we_stall  = dest.we & late_result;
    assign we_bypass = dest.we & ~late_result;

endmodule

// File: rtl/hazard_decode_unit.sv
// Decode-stage RAW hazard detection: rs forwarding from EXE, stall otherwise, stall-cycle counter.
module hazard_decode_unit
    import mips_isa_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  inst_id,
    input  logic [XLEN-1:0]  inst_exe,
    input  logic [XLEN-1:0]  inst_mem,
    input  logic [XLEN-1:0]  inst_wb,
    output logic             re1,
    output logic             re2,
    output logic [REG_W-1:0] ws_exe,
    output logic [REG_W-1:0] ws_mem,
    output logic [REG_W-1:0] ws_wb,
    output logic             we_exe,
    output logic             we_mem,
    output logic             we_wb,
    output logic             we_bypass,
    output logic             we_stall,
    output logic             bypass_rs,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    logic [OP_W-1:0]  op_id;
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    reads_t           reads;
    logic             rs_hazard;
    logic             rt_hazard;
    logic             unused_mem_bypass;
    logic             unused_mem_stall;
    logic             unused_wb_bypass;
    logic             unused_wb_stall;
    logic             unused_id_low;

    assign op_id         = inst_id[31:26];
    assign rs_id         = inst_id[25:21];
    assign rt_id         = inst_id[20:16];
    assign unused_id_low = ^inst_id[15:0];

    dest_decoder u_dec_exe (
        .inst      (inst_exe),
        .ws        (ws_exe),
        .we        (we_exe),
        .we_bypass (we_bypass),
        .we_stall  (we_stall)
    );

    dest_decoder u_dec_mem (
        .inst      (inst_mem),
        .ws        (ws_mem),
        .we        (we_mem),
        .we_bypass (unused_mem_bypass),
        .we_stall  (unused_mem_stall)
    );

    dest_decoder u_dec_wb (
        .inst      (inst_wb),
        .ws        (ws_wb),
        .we        (we_wb),
        .we_bypass (unused_wb_bypass),
        .we_stall  (unused_wb_stall)
    );

    // Source-register usage from the opcode alone.
    always_comb begin
        reads = '0;
        unique case (op_id)
            OP_RTYPE, OP_SW, OP_BEQ, OP_BNE:             reads = '{re1: 1'b1, re2: 1'b1};
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW:    reads = '{re1: 1'b1, re2: 1'b0};
            default:                                     reads = '0;
        endcase
    end

    assign re1 = reads.re1;
    assign re2 = reads.re2;

    // rs may take the EXE ALU result; rt has no forwarding path.
    assign bypass_rs = re1 & we_bypass & (rs_id == ws_exe);

    assign rs_hazard = re1 & (((rs_id == ws_exe) & we_stall) |
                              ((rs_id == ws_mem) & we_mem)   |
                              ((rs_id == ws_wb)  & we_wb));
    assign rt_hazard = re2 & (((rt_id == ws_exe) & we_exe)   |
                              ((rt_id == ws_mem) & we_mem)   |
                              ((rt_id == ws_wb)  & we_wb));

    assign stall = rs_hazard | rt_hazard;

    // Free-running stall-cycle counter, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stall) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_decode_unit.sv
// Directed bench for hazard_decode_unit with hand-computed expectations.
module tb_hazard_decode_unit;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      inst_id, inst_exe, inst_mem, inst_wb;
    logic             re1, re2;
    logic [4:0]       ws_exe, ws_mem, ws_wb;
    logic             we_exe, we_mem, we_wb;
    logic             we_bypass, we_stall, bypass_rs, stall;
    logic [CNT_W-1:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [CNT_W-1:0] exp_cnt;

    hazard_decode_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_id     (inst_id),
        .inst_exe    (inst_exe),
        .inst_mem    (inst_mem),
        .inst_wb     (inst_wb),
        .re1         (re1),
        .re2         (re2),
        .ws_exe      (ws_exe),
        .ws_mem      (ws_mem),
        .ws_wb       (ws_wb),
        .we_exe      (we_exe),
        .we_mem      (we_mem),
        .we_wb       (we_wb),
        .we_bypass   (we_bypass),
        .we_stall    (we_stall),
        .bypass_rs   (bypass_rs),
        .stall       (stall),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int func);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(func)};
    endfunction

    function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_insts(input logic [31:0] id, input logic [31:0] exe,
                             input logic [31:0] mem, input logic [31:0] wb);
        @(negedge clk);
        inst_id  = id;
        inst_exe = exe;
        inst_mem = mem;
        inst_wb  = wb;
        #1;
    endtask

    task automatic tick_count(input string tag);
        @(posedge clk);
        #1;
        exp_cnt = exp_cnt + CNT_W'(1);
        check(tag, 32'(stall_count), 32'(exp_cnt));
    endtask

    initial begin
        rst      = 1'b0;
        inst_id  = '0;
        inst_exe = '0;
        inst_mem = '0;
        inst_wb  = '0;
        exp_cnt  = '0;
        #2;
        check("reset_count", 32'(stall_count), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // add $3,$1,$2 in EXE feeds sub $4,$3,$5 via bypass
        set_insts(r_type(3, 5, 4, 'h22), r_type(1, 2, 3, 'h20), '0, '0);
        check("alu_ws_exe", 32'(ws_exe), 32'd3);
        check("alu_we_bypass", 32'(we_bypass), 32'd1);
        check("alu_we_stall", 32'(we_stall), 32'd0);
        check("alu_bypass_rs", 32'(bypass_rs), 32'd1);
        check("alu_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check("alu_count_hold", 32'(stall_count), 32'd0);

        // lw $3,0($1) in EXE; add $4,$3,$2 must stall
        set_insts(r_type(3, 2, 4, 'h20), i_type('h23, 1, 3, 0), '0, '0);
        check("lw_we_stall", 32'(we_stall), 32'd1);
        check("lw_we_exe", 32'(we_exe), 32'd1);
        check("lw_bypass_rs", 32'(bypass_rs), 32'd0);
        check("lw_stall", 32'(stall), 32'd1);
        for (int i = 0; i < 3; i++) tick_count("lw_count");

        // addi $7,$0,5 in MEM; sw $7,0($1) stalls on rt
        set_insts(i_type('h2b, 1, 7, 0), '0, i_type('h08, 0, 7, 5), '0);
        check("sw_re1", 32'(re1), 32'd1);
        check("sw_re2", 32'(re2), 32'd1);
        check("sw_ws_mem", 32'(ws_mem), 32'd7);
        check("sw_stall", 32'(stall), 32'd1);
        tick_count("sw_count");

        // jal in EXE; jr $31 stalls
        set_insts(r_type(31, 0, 0, 'h08), {6'b000011, 26'h0000100}, '0, '0);
        check("jal_ws_exe", 32'(ws_exe), 32'd31);
        check("jal_we_stall", 32'(we_stall), 32'd1);
        check("jal_we_bypass", 32'(we_bypass), 32'd0);
        check("jal_stall", 32'(stall), 32'd1);
        tick_count("jal_count");

        // NOPs everywhere
        set_insts('0, '0, '0, '0);
        check("nop_we_exe", 32'(we_exe), 32'd0);
        check("nop_we_mem", 32'(we_mem), 32'd0);
        check("nop_we_wb", 32'(we_wb), 32'd0);
        check("nop_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check("nop_count_hold", 32'(stall_count), 32'(exp_cnt));

        // add $0,$1,$2 everywhere, id reads $0 on both ports
        set_insts(r_type(0, 0, 5, 'h20), r_type(1, 2, 0, 'h20), r_type(1, 2, 0, 'h20), r_type(1, 2, 0, 'h20));
        check("zero_ws_exe", 32'(ws_exe), 32'd0);
        check("zero_we_exe", 32'(we_exe), 32'd0);
        check("zero_bypass_rs", 32'(bypass_rs), 32'd0);
        check("zero_stall", 32'(stall), 32'd0);

        // jr in EXE does not write
        set_insts(r_type(31, 0, 4, 'h20), r_type(31, 0, 0, 'h08), '0, '0);
        check("jr_we_exe", 32'(we_exe), 32'd0);
        check("jr_stall", 32'(stall), 32'd0);

        // addi $9 in WB; addi $10,$9,2 stalls on rs
        set_insts(i_type('h08, 9, 10, 2), '0, '0, i_type('h08, 0, 9, 1));
        check("wb_ws_wb", 32'(ws_wb), 32'd9);
        check("wb_re2", 32'(re2), 32'd0);
        check("wb_stall", 32'(stall), 32'd1);
        tick_count("wb_count");

        // lui reads nothing even if fields collide with WB dest
        set_insts(i_type('h0f, 9, 9, 1), '0, '0, i_type('h08, 0, 9, 1));
        check("lui_re1", 32'(re1), 32'd0);
        check("lui_stall", 32'(stall), 32'd0);

        // rt of id matches a bypassable EXE writer: no rt forwarding -> stall
        set_insts(r_type(5, 3, 4, 'h22), r_type(1, 2, 3, 'h20), '0, '0);
        check("rt_bypass_rs", 32'(bypass_rs), 32'd0);
        check("rt_stall", 32'(stall), 32'd1);
        for (int i = 0; i < 16; i++) tick_count("wrap_count");
        check("wrap_full_cycle", 32'(stall_count), 32'(exp_cnt));

        // Run up to all-ones then confirm the wrap edge explicitly
        while (stall_count != '1) tick_count("to_ones");
        tick_count("wrap_to_zero");
        check("wrap_is_zero", 32'(stall_count), 32'd0);
        tick_count("after_wrap");

        // Async reset mid-count, comb outputs stay live
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        exp_cnt = '0;
        check("async_rst_count", 32'(stall_count), 32'd0);
        check("rst_stall_live", 32'(stall), 32'd1);
        check("rst_ws_exe_live", 32'(ws_exe), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        tick_count("resume_count");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
